// File: rtl/npc_bpred_pkg.sv
// Shared definitions for the npc_bpred next-PC predictor: 2-bit counter
// encodings, reset/allocation counter states, default reset PC and the
// saturating counter step function.
package npc_bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e        CTR_RESET        = WNT;
    localparam ctr_e        CTR_ALLOC        = WT;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Saturating 2-bit counter step: SNT and ST stick at the ends.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: valid/tag/target/counter arrays with
// one combinational lookup port and one update port written at the clock
// edge. Lookup always returns pre-update contents (no write bypass).
// Word addresses only: callers pass pc[PC_W-1:2].
module npc_btb
    import npc_bpred_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:2] lk_pc,
    output logic            lk_taken,
    output logic [PC_W-1:0] lk_target,
    input  logic            wr_en,
    input  logic [PC_W-1:2] wr_pc,
    input  logic            wr_taken,
    input  logic [PC_W-1:2] wr_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-3:0]  target_q [ENTRIES];
    logic [PC_W-3:0]  target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             lk_hit;
    logic             wr_hit;

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[PC_W-1:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Zero-latency lookup of the current fetch PC.
    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && ctr_q[lk_idx][1];
        lk_target = {target_q[lk_idx], 2'b00};
    end

    // Next array state: train on a hit, allocate on a taken miss, else keep.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (wr_en) begin
            if (wr_hit) begin
                ctr_d[wr_idx] = ctr_next(ctr_e'(ctr_q[wr_idx]), wr_taken);
                if (wr_taken) begin
                    target_d[wr_idx] = wr_target;
                end else begin
                    target_d[wr_idx] = target_q[wr_idx];
                end
            end else if (wr_taken) begin
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = wr_target;
                ctr_d[wr_idx]    = CTR_ALLOC;
            end else begin
                // not-taken miss leaves the entry untouched
                valid_d[wr_idx] = valid_q[wr_idx];
            end
        end else begin
            valid_d[wr_idx] = valid_q[wr_idx];
        end
    end

    // Valid bits and counters: cleared to empty/weakly-not-taken on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/npc_bpred.sv
// Fetch-stage next-PC unit: owns the fetch PC register, predicts the next
// PC through a direct-mapped BTB, detects mispredicts reported by the
// resolve stage and redirects fetch.
// Optional build macro NPC_BPRED_STATS_EN adds saturating branch and
// mispredict counters (stat_branches, stat_mispredicts).
module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter int              ENTRIES  = 16,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc
`ifdef NPC_BPRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(3'd4);
    localparam logic [PC_W-1:0] PC_RST_ALN = {RESET_PC[PC_W-1:2], 2'b00};

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] upd_plus4;
    logic            btb_taken;
    logic [PC_W-1:0] btb_target;
    logic            btb_wr_en;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + PC_STEP;
    assign upd_plus4 = upd_pc + PC_STEP;
    assign btb_wr_en = upd_valid && !reset;

    npc_btb #(
        .ENTRIES (ENTRIES),
        .PC_W    (PC_W)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lk_pc     (pc_q[PC_W-1:2]),
        .lk_taken  (btb_taken),
        .lk_target (btb_target),
        .wr_en     (btb_wr_en),
        .wr_pc     (upd_pc[PC_W-1:2]),
        .wr_taken  (upd_taken),
        .wr_target (upd_target[PC_W-1:2])
    );

    // Prediction for the current fetch PC.
    always_comb begin
        pred_taken = btb_taken;
        if (btb_taken) begin
            pred_target = btb_target;
        end else begin
            pred_target = pc_plus4;
        end
    end

    // Mispredict detection and the corrected fetch address.
    always_comb begin
        flush = upd_valid && ((upd_taken != upd_pred_taken) ||
                              (upd_taken && (upd_target != upd_pred_target)) ||
                              (!upd_taken && (upd_pred_target != upd_plus4)));
        if (upd_taken) begin
            redirect_pc = {upd_target[PC_W-1:2], 2'b00};
        end else begin
            redirect_pc = {upd_plus4[PC_W-1:2], 2'b00};
        end
    end

    // Next fetch PC: a redirect beats a stall, otherwise follow the prediction.
    always_comb begin
        if (flush) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target;
        end
    end

    // Fetch PC register; reset wins over any redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RST_ALN;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef NPC_BPRED_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_br_d;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_mis_d;

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

    // Saturating event counters for resolved branches and mispredicts.
    always_comb begin
        if (upd_valid && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end else begin
            stat_br_d = stat_br_q;
        end
        if (flush && (stat_mis_q != 32'hFFFF_FFFF)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end else begin
            stat_mis_d = stat_mis_q;
        end
    end

    // Statistics registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end
`endif

endmodule

// File: tb/tb_npc_bpred.sv
// Directed self-checking bench for npc_bpred (ENTRIES=16, RESET_PC=3000).
// Inputs change 1 time unit after each rising edge; outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_npc_bpred;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef NPC_BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    npc_bpred dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pc              (pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .flush           (flush),
        .redirect_pc     (redirect_pc)
`ifdef NPC_BPRED_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = p;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
    endtask

    task automatic clr();
        upd_valid       = 1'b0;
        upd_pc          = 32'd0;
        upd_taken       = 1'b0;
        upd_target      = 32'd0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        clr();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        // 1: reset state and sequential fetch
        chk("rst_pc", pc, 32'h3000);
        chk("rst_pred_taken", pred_taken, 32'd0);
        chk("rst_pred_target", pred_target, 32'h3004);
        chk("rst_flush", flush, 32'd0);
        cyc(); #1;
        chk("seq_pc1", pc, 32'h3004);
        chk("seq_flush1", flush, 32'd0);
        cyc(); #1;
        chk("seq_pc2", pc, 32'h3008);
        chk("seq_pred2", pred_taken, 32'd0);

        // 2: taken branch not predicted -> flush and allocate
        upd(32'h300C, 1'b1, 32'h3040, 1'b0, 32'h3010); #1;
        chk("mp_flush", flush, 32'd1);
        chk("mp_redirect", redirect_pc, 32'h3040);
        cyc(); clr(); #1;
        chk("mp_pc", pc, 32'h3040);
        upd(32'h3008, 1'b0, 32'h0, 1'b0, 32'h3040); #1;
        chk("nt_flush", flush, 32'd1);
        chk("nt_redirect", redirect_pc, 32'h300C);
        cyc(); clr(); #1;
        chk("refetch_pc", pc, 32'h300C);
        chk("refetch_pred", pred_taken, 32'd1);
        chk("refetch_target", pred_target, 32'h3040);

        // 3/6: counter training while stalled; same-idx lookup sees old state
        stall = 1'b1;
        upd(32'h300C, 1'b0, 32'h0, 1'b0, 32'h3010); #1;
        chk("nt1_flush", flush, 32'd0);
        chk("same_idx_old_pred", pred_taken, 32'd1);
        cyc(); clr(); #1;
        chk("nt1_pc_hold", pc, 32'h300C);
        chk("nt1_pred", pred_taken, 32'd0);
        chk("nt1_target", pred_target, 32'h3010);
        upd(32'h300C, 1'b0, 32'h0, 1'b0, 32'h3010);
        cyc(); clr(); #1;
        chk("nt2_pred", pred_taken, 32'd0);
        upd(32'h300C, 1'b0, 32'h0, 1'b0, 32'h3010);
        cyc(); clr(); #1;
        upd(32'h300C, 1'b1, 32'h3044, 1'b1, 32'h3044); #1;
        chk("t_ok_flush", flush, 32'd0);
        cyc(); clr(); #1;
        chk("sat_low_pred", pred_taken, 32'd0);
        upd(32'h300C, 1'b1, 32'h3044, 1'b1, 32'h3044);
        cyc(); clr(); #1;
        chk("retrain_pred", pred_taken, 32'd1);
        chk("retrain_target", pred_target, 32'h3044);

        // 5: stall holds for 3 cycles, flush overrides stall
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("stall_hold", pc, 32'h300C);
        end
        upd(32'h3100, 1'b1, 32'h3500, 1'b0, 32'h3104); #1;
        chk("stall_flush", flush, 32'd1);
        cyc(); clr(); stall = 1'b0; #1;
        chk("stall_flush_pc", pc, 32'h3500);

        // 4: index alias replacement
        upd(32'h3000, 1'b1, 32'h3100, 1'b0, 32'h3004);
        cyc(); clr(); #1;
        chk("alias_pc1", pc, 32'h3100);
        chk("alias_miss_pred", pred_taken, 32'd0);
        chk("alias_miss_target", pred_target, 32'h3104);
        upd(32'h3040, 1'b1, 32'h3200, 1'b0, 32'h3044);
        cyc(); clr(); #1;
        chk("alias_pc2", pc, 32'h3200);
        upd(32'h2FFC, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); clr(); #1;
        chk("alias_pc3000", pc, 32'h3000);
        chk("alias_3000_pred", pred_taken, 32'd0);
        chk("alias_3000_target", pred_target, 32'h3004);
        upd(32'h303C, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); clr(); #1;
        chk("alias_pc3040", pc, 32'h3040);
        chk("alias_3040_pred", pred_taken, 32'd1);
        chk("alias_3040_target", pred_target, 32'h3200);

        // 6: reset with a simultaneous update -> empty BTB
        reset = 1'b1;
        upd(32'h3080, 1'b1, 32'h3300, 1'b0, 32'h3084);
        cyc(); reset = 1'b0; clr(); #1;
        chk("mid_rst_pc", pc, 32'h3000);
        chk("mid_rst_pred", pred_taken, 32'd0);
        chk("mid_rst_flush", flush, 32'd0);
        upd(32'h307C, 1'b0, 32'h0, 1'b0, 32'h0); #1;
        chk("to3080_flush", flush, 32'd1);
        chk("to3080_redirect", redirect_pc, 32'h3080);
        cyc(); clr(); #1;
        chk("mid_rst_3080_pc", pc, 32'h3080);
        chk("mid_rst_3080_pred", pred_taken, 32'd0);

        // wrap-around of pc+4 and upd_pc+4
        upd(32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); clr(); #1;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pred_target", pred_target, 32'h0);
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0); #1;
        chk("wrap_upd_flush", flush, 32'd0);
        chk("wrap_redirect", redirect_pc, 32'h0);
        cyc(); clr(); #1;
        chk("wrap_pc0", pc, 32'h0);

        // two more correctly predicted resolves: 5 resolves, 2 mispredicts since reset
        upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h4);
        cyc();
        upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h4);
        cyc(); clr(); #1;
`ifdef NPC_BPRED_STATS_EN
        chk("stat_branches", stat_branches, 32'd5);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
